// File: rtl/exchange_pkg.sv
// rtl/exchange_pkg.sv - shared state encoding and neighbor count for the exchange scheduler
package exchange_pkg;

    localparam int NEIGHBOR_COUNT = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COMPUTE   = 3'd1,
        ST_WAIT_CTS  = 3'd2,
        ST_SEND      = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_ADVANCE   = 3'd5,
        ST_ERROR     = 3'd6
    } state_t;

endpackage

// File: rtl/watchdog_counter.sv
// rtl/watchdog_counter.sv - handshake wait watchdog; expired once the count reaches TIMEOUT_CYCLES-1
module watchdog_counter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LIMIT = (TIMEOUT_CYCLES > 0) ? W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count;

    // Holds at the limit so a stalled consumer never sees the count wrap.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + ONE;
        end
    end

    assign expired = (TIMEOUT_CYCLES > 0) && (count == LIMIT);

endmodule

// File: rtl/exchange_scheduler.sv
// rtl/exchange_scheduler.sv - per-layer compute/halo-exchange sequencer for one PPU tile
module exchange_scheduler
    import exchange_pkg::*;
#(
    parameter int NEIGHBOR_COUNT = exchange_pkg::NEIGHBOR_COUNT,
    parameter int GROUP_WIDTH    = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [GROUP_WIDTH-1:0]    group_count,
    input  logic [NEIGHBOR_COUNT-1:0] neighbor_mask,
    input  logic                      cycle_done,
    input  logic                      local_send_done,
    input  logic [NEIGHBOR_COUNT-1:0] neighbor_cts,
    input  logic [NEIGHBOR_COUNT-1:0] neighbor_exchange_done,
    output logic                      compute_enable,
    output logic                      send_enable,
    output logic                      clear_to_send,
    output logic                      exchange_done,
    output logic                      channel_group_done,
    output logic                      layer_done,
    output logic [GROUP_WIDTH-1:0]    group_index,
    output logic                      busy,
    output logic                      timeout_error
);

    localparam logic [GROUP_WIDTH-1:0] ONE = GROUP_WIDTH'(1);

    state_t                    state;
    state_t                    next_state;
    logic [GROUP_WIDTH-1:0]    count_q;
    logic [NEIGHBOR_COUNT-1:0] mask_q;
    logic                      cts_ok;
    logic                      xchg_ok;
    logic                      last_group;
    logic                      expired;
    logic                      wd_clear;
    logic                      wd_enable;

    // An absent neighbor counts as ready, so an empty mask passes straight through.
    assign cts_ok     = (neighbor_cts & mask_q) == mask_q;
    assign xchg_ok    = (neighbor_exchange_done & mask_q) == mask_q;
    assign last_group = group_index == (count_q - ONE);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      if (start && group_count != '0) next_state = ST_COMPUTE;
            ST_COMPUTE:   if (cycle_done) next_state = ST_WAIT_CTS;
            ST_WAIT_CTS: begin
                if (cts_ok)       next_state = ST_SEND;
                else if (expired) next_state = ST_ERROR;
            end
            ST_SEND:      if (local_send_done) next_state = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (xchg_ok)      next_state = ST_ADVANCE;
                else if (expired) next_state = ST_ERROR;
            end
            ST_ADVANCE:   next_state = last_group ? ST_IDLE : ST_COMPUTE;
            ST_ERROR:     next_state = ST_ERROR;
            default:      next_state = ST_IDLE;
        endcase
    end

    assign wd_clear  = (next_state == ST_WAIT_CTS  && state != ST_WAIT_CTS) ||
                       (next_state == ST_WAIT_DONE && state != ST_WAIT_DONE);
    assign wd_enable = (state == ST_WAIT_CTS  && !cts_ok) ||
                       (state == ST_WAIT_DONE && !xchg_ok);

    watchdog_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(expired)
    );

    // Outputs decode next_state so each registered flag lines up with the state it describes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= ST_IDLE;
            count_q            <= '0;
            mask_q             <= '0;
            group_index        <= '0;
            compute_enable     <= 1'b0;
            send_enable        <= 1'b0;
            clear_to_send      <= 1'b0;
            exchange_done      <= 1'b0;
            channel_group_done <= 1'b0;
            layer_done         <= 1'b0;
            busy               <= 1'b0;
            timeout_error      <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && start) begin
                count_q     <= group_count;
                mask_q      <= neighbor_mask;
                group_index <= '0;
            end else if (state == ST_ADVANCE && !last_group) begin
                group_index <= group_index + ONE;
            end
            compute_enable     <= next_state == ST_COMPUTE;
            clear_to_send      <= next_state == ST_WAIT_CTS || next_state == ST_SEND;
            send_enable        <= next_state == ST_SEND;
            exchange_done      <= next_state == ST_WAIT_DONE;
            channel_group_done <= next_state == ST_ADVANCE;
            layer_done         <= (next_state == ST_ADVANCE && last_group) ||
                                  (state == ST_IDLE && start && group_count == '0);
            busy               <= next_state != ST_IDLE;
            timeout_error      <= next_state == ST_ERROR;
        end
    end

endmodule
